// File: rtl/tinker_fetch_queue_if.sv
// tinker_fetch_queue_if: bundles the instruction-memory request/response,
// decoder hand-off and redirect signals of the Tinker fetch queue.
// The master modport is the fetch queue; the slave modport is its
// surroundings (instruction memory, decoder and branch unit together).
interface tinker_fetch_queue_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   modport master (
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_addr,
      input  imem_resp_valid,
      input  imem_resp_data,
      output inst_valid,
      input  inst_ready,
      output inst_data,
      output inst_pc,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_addr,
      output imem_resp_valid,
      output imem_resp_data,
      input  inst_valid,
      output inst_ready,
      input  inst_data,
      input  inst_pc,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue: sequential instruction prefetch for the Tinker core.
// Issues word fetches from fetch_pc, buffers returned words together with
// their PCs in an in-order queue and hands them to the decoder. Redirects
// restart fetching, flush the queue and squash responses still in flight.
// Optional feature: define FETCHQ_BYPASS_EN to forward a response straight
// to the decoder in the same cycle when the queue is empty.
module tinker_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h2000
) (
   input  logic                 clk,
   input  logic                 reset,
   tinker_fetch_queue_if.master bus
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(DEPTH);

   // Control state.
   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [PW-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
   logic [PW-1:0] tag_wr_ptr_q, tag_wr_ptr_d;

   // Queue entries and the address tag of every request still in flight.
   // Squashed requests keep their tags until their responses return, so the
   // memory side must never hold more than DEPTH responses in flight.
   logic [31:0] entry_data_q [DEPTH];
   logic [63:0] entry_pc_q   [DEPTH];
   logic [63:0] tag_pc_q     [DEPTH];

   logic [CW:0]  in_use;
   logic         req_valid;
   logic         req_fire;
   logic         resp_live;
   logic         resp_drop;
   logic         head_valid;
   logic         bypass;
   logic         pop;
   logic         push;
   logic [63:0]  resp_pc;

   // Decode this cycle's handshakes and where a live response goes.
   // NOTE: every always_comb output gets a default before any branch;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      in_use     = {1'b0, count_q} + {1'b0, outstanding_q};
      req_valid  = !reset && !bus.redirect_valid && (in_use < DEPTH_LIMIT);
      req_fire   = req_valid && bus.imem_req_ready;
      resp_live  = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;
      resp_drop  = bus.imem_resp_valid && (drop_q != '0) && !bus.redirect_valid;
      head_valid = (count_q != '0);
      resp_pc    = tag_pc_q[tag_rd_ptr_q];
`ifdef FETCHQ_BYPASS_EN
      bypass     = !reset && !head_valid && resp_live;
`else
      bypass     = 1'b0;
`endif
      pop        = head_valid && bus.inst_ready && !bus.redirect_valid;
      // A bypassed word the decoder takes right away never enters the queue.
      push       = resp_live && !(bypass && bus.inst_ready);
   end

   // Next-state for pointers, counters and the fetch address.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      tag_rd_ptr_d  = tag_rd_ptr_q;
      tag_wr_ptr_d  = tag_wr_ptr_q;

      // Every response retires the oldest tag, whether kept or squashed.
      if (bus.imem_resp_valid) begin
         tag_rd_ptr_d = tag_rd_ptr_q + PW'(1);
      end
      if (req_fire) begin
         tag_wr_ptr_d = tag_wr_ptr_q + PW'(1);
      end

      if (bus.redirect_valid) begin
         // Everything in flight becomes stale; a response returning right
         // now is one of those and is already being thrown away.
         fetch_pc_d    = bus.redirect_pc;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         count_d       = '0;
         outstanding_d = '0;
         drop_d        = drop_q + outstanding_q - CW'(bus.imem_resp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (resp_drop) begin
            drop_d = drop_q - CW'(1);
         end
         count_d       = count_q + CW'(push) - CW'(pop);
         outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_live);
      end
   end

   // Control registers, cleared by the asynchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         tag_rd_ptr_q  <= '0;
         tag_wr_ptr_q  <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         tag_rd_ptr_q  <= tag_rd_ptr_d;
         tag_wr_ptr_q  <= tag_wr_ptr_d;
      end
   end

   // Write queue entries and request tags.
   // NOTE: the storage arrays have no reset; the pointers and counters
   // decide which entries are meaningful, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         entry_data_q[wr_ptr_q] <= bus.imem_resp_data;
         entry_pc_q[wr_ptr_q]   <= resp_pc;
      end
      if (req_fire) begin
         tag_pc_q[tag_wr_ptr_q] <= fetch_pc_q;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.inst_valid     = head_valid || bypass;
   assign bus.inst_data      = bypass     ? bus.imem_resp_data :
                               head_valid ? entry_data_q[rd_ptr_q] : 32'h0;
   assign bus.inst_pc        = bypass     ? resp_pc :
                               head_valid ? entry_pc_q[rd_ptr_q] : 64'h0;

endmodule

// File: doc/tinker_fetch_queue.md
# tinker_fetch_queue

Instruction prefetch stage for the Tinker core. Generates sequential 32-bit instruction fetches from byte-addressed instruction memory over a valid/ready request port. Buffers returned words with their PCs in an in-order queue and presents them to the instruction decoder over a valid/ready port. Branch/call/return redirects flush the queue and squash in-flight responses.

## Interface
- `DEPTH`, default 4: queue entries and maximum outstanding requests combined; power of two, 2..16.
- `RESET_PC`, default 64'h2000: first fetch address after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_req_addr` output 64: byte address of the requested word.
- `imem_resp_valid` input 1: response word valid. Responses return in request order with latency ≥1 cycle. Always accepted.
- `imem_resp_data` input 32: instruction word, little-endian as assembled by memory.
- `inst_valid` output 1: head entry valid toward the decoder.
- `inst_ready` input 1: decoder consumes the head entry.
- `inst_data` output 32: head instruction word; 0 when `inst_valid`=0.
- `inst_pc` output 64: PC of the head instruction; 0 when `inst_valid`=0.
- `redirect_valid` input 1: control flow changed; restart fetching.
- `redirect_pc` input 64: new fetch address.

## Operation
- State:
  - `fetch_pc` (64b).
  - Queue of DEPTH entries, each {data, pc}, with rd/wr pointers and `count`.
  - `outstanding`: accepted requests not yet answered.
  - `drop`: in-flight responses to discard.
  - Per-request PC FIFO of DEPTH entries, tagging each outstanding request with its address.
- Request issue:
  - `imem_req_valid` = !redirect_valid && (count + outstanding < DEPTH).
  - `imem_req_addr` = fetch_pc.
  - On handshake: fetch_pc += 4, with 64-bit wrap modulo 2^64; outstanding += 1; push fetch_pc to the PC FIFO.
- Response:
  - If `drop` > 0: discard the word, drop -= 1, pop the PC FIFO.
  - Otherwise: write {data, tagged pc} at the queue tail, count += 1, outstanding -= 1.
  - The credit rule guarantees the queue never overflows.
- Dequeue: `inst_valid` && `inst_ready` pops the head; count -= 1.
- Redirect, when `redirect_valid`=1 in a cycle:
  - fetch_pc ← redirect_pc.
  - Queue flushed: count ← 0, pointers reset.
  - drop ← drop + outstanding − (1 if a response arrives this cycle, else 0).
  - outstanding ← 0.
  - PC FIFO entries are kept for drop bookkeeping.
  - A pop by `inst_ready` in the same cycle is ignored.
  - A response arriving in the same cycle is discarded.
  - The first request to redirect_pc issues the next cycle.
- Simultaneous response and dequeue in the same cycle: count unchanged, both pointers advance.
- Back-to-back redirects: each cycle overrides the previous one. The latest redirect_pc wins.
- `redirect_pc` low bits are not checked; misaligned addresses are fetched as given.

## Timing
- Reset, while asserted and immediately after:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0.
  - Counters and pointers are 0.
- First cycle after reset deasserts: `imem_req_valid`=1, addr=RESET_PC.
- Response-to-decoder latency:
  - Without bypass: a word received in cycle N is visible on `inst_valid` in cycle N+1.
- Throughput: one instruction per cycle sustained when memory latency ≤ DEPTH−1.
- Redirect-to-first-request: 1 cycle.
- Reset asserted mid-operation: all state cleared immediately. Pending responses after reset are not dropped. The memory is reset by the same signal.

## Configuration
- `FETCHQ_BYPASS_EN` defined:
  - When the queue is empty, drop=0, no redirect, and `imem_resp_valid`=1, the response drives `inst_valid`/`inst_data`/`inst_pc` combinationally in the same cycle.
  - If `inst_ready`=1, it is not written into the queue.
  - Latency becomes 0 cycles.
- Undefined: no combinational path from `imem_resp_*` to `inst_*`. Latency is 1 cycle.

## Test plan
- Reset release, memory latency 1, `inst_ready`=1:
  - Requests at 0x2000, 0x2004, 0x2008 on consecutive cycles.
  - Decoder sees pc 0x2000/0x2004/0x2008 with matching words, one per cycle after the first.
- `inst_ready`=0 for 10 cycles, DEPTH=4:
  - Exactly 4 requests issue, then `imem_req_valid`=0.
  - count=4.
  - On release, all 4 are drained in order.
- Redirect to 0x3000 with 2 responses outstanding:
  - Those 2 responses are discarded.
  - Next request addr=0x3000.
  - First `inst_pc` seen is 0x3000.
- Redirect coincident with a response and with `inst_ready`=1:
  - Queue is empty next cycle.
  - The response is not delivered.
  - drop equals outstanding−1.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC:
  - Next request addr is 0.
- With `FETCHQ_BYPASS_EN`, empty queue:
  - Response 32'hC8400000 appears on `inst_data` in the same cycle as `imem_resp_valid`.
- Without `FETCHQ_BYPASS_EN`, empty queue:
  - The same response appears one cycle later.
